// File: rtl/score_keeper.sv
// score_keeper: BCD run score, session high score, speed level, milestone pulse.
// Ports: clk, rst (sync, active-high), state[1:0] in; score, hi_score, level, new_hi, milestone out.
module score_keeper #(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MS_DIGITS = 2,
  parameter int unsigned MAX_LEVEL = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            state,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hi_score,
  output logic [2:0]            level,
  output logic                  new_hi,
  output logic                  milestone
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned MW = 4 * MS_DIGITS;
  localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_DEAD = 2'b01;
  localparam logic [1:0] ST_GAME = 2'b10;

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [2:0]    LVL_MAX  = 3'(MAX_LEVEL);

  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] hi_q, hi_d;
  logic [2:0]    level_q, level_d;
  logic          new_hi_q, new_hi_d;
  logic          ms_q, ms_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    prev_q;

  logic          in_game;
  logic          in_dead;
  logic          in_init;
  logic          tick;

  logic [SW-1:0] score_inc;
  logic          saturated;
  logic          bump;
  logic          hit_ms;

  assign in_game = (state == ST_GAME);
  assign in_dead = (state == ST_DEAD);
  // 2'b11 is folded into Init
  assign in_init = !in_game && !in_dead;
  assign tick    = in_game && (div_q == DIV_LAST);

  // Ripple BCD +1; all-nines means the score is pinned
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    carry     = 1'b1;
    dig       = '0;
    score_inc = '0;
    saturated = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = score_q[4*i +: 4];
      if (dig != 4'd9) saturated = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        score_inc[4*i +: 4] = dig;
      end
    end
  end

  assign bump   = tick && !saturated;
  assign hit_ms = bump && (score_inc[MW-1:0] == '0);

  always_comb begin
    score_d  = score_q;
    hi_d     = hi_q;
    level_d  = level_q;
    new_hi_d = new_hi_q;
    div_d    = div_q;
    ms_d     = 1'b0;
    unique case (1'b1)
      in_init: begin
        score_d  = '0;
        div_d    = '0;
        level_d  = '0;
        new_hi_d = 1'b0;
      end
      in_game: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (bump) score_d = score_inc;
        if (hit_ms) begin
          ms_d = 1'b1;
          if (level_q < LVL_MAX) level_d = level_q + 3'd1;
        end
      end
      in_dead: begin
        // Score is frozen here, so compare the registered value
        if (prev_q == ST_GAME) begin
          if (score_q > hi_q) begin
            hi_d     = score_q;
            new_hi_d = 1'b1;
          end else begin
            new_hi_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q  <= '0;
      hi_q     <= '0;
      level_q  <= '0;
      new_hi_q <= 1'b0;
      ms_q     <= 1'b0;
      div_q    <= '0;
      prev_q   <= ST_INIT;
    end else begin
      score_q  <= score_d;
      hi_q     <= hi_d;
      level_q  <= level_d;
      new_hi_q <= new_hi_d;
      ms_q     <= ms_d;
      div_q    <= div_d;
      prev_q   <= state;
    end
  end

  assign score     = score_q;
  assign hi_score  = hi_q;
  assign level     = level_q;
  assign new_hi    = new_hi_q;
  assign milestone = ms_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed tests for score_keeper.
// TICK_DIV=4, DIGITS=4, MS_DIGITS=2, MAX_LEVEL=7.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic [2:0]  level;
  logic        new_hi;
  logic        milestone;

  int errors = 0;
  int checks = 0;

  score_keeper #(
    .TICK_DIV (4),
    .DIGITS   (4),
    .MS_DIGITS(2),
    .MAX_LEVEL(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .score    (score),
    .hi_score (hi_score),
    .level    (level),
    .new_hi   (new_hi),
    .milestone(milestone)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step until score reaches tgt (bounded); counts milestone pulses seen
  task automatic run_to(input logic [15:0] tgt, input int budget,
                        output int ms);
    int k;
    ms = 0;
    k  = 0;
    while (score !== tgt && k < budget) begin
      @(negedge clk);
      if (milestone === 1'b1) ms++;
      k++;
    end
    checks++;
    if (score !== tgt) begin
      errors++;
      $display("FAIL run_to: score=%h required=%h", score, tgt);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    state = 2'b10;
    step(2);
    checks++;
    if (score !== 16'h0000) begin
      errors++; $display("FAIL rst_score: got=%h want=0000", score);
    end
    checks++;
    if (hi_score !== 16'h0000) begin
      errors++; $display("FAIL rst_hi: got=%h want=0000", hi_score);
    end
    checks++;
    if (level !== 3'd0 || new_hi !== 1'b0 || milestone !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: lvl=%0d nh=%b ms=%b want 0/0/0",
               level, new_hi, milestone);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (score !== 16'h0000) begin
      errors++; $display("FAIL rel_score: got=%h want=0000", score);
    end
    state = 2'b00;
    step(1);
  endtask

  task automatic test_count;
    int ms;
    ms    = 0;
    state = 2'b10;
    repeat (48) begin
      step(1);
      if (milestone === 1'b1) ms++;
    end
    checks++;
    if (score !== 16'h0012) begin
      errors++; $display("FAIL count48: got=%h want=0012", score);
    end
    checks++;
    if (level !== 3'd0 || ms != 0) begin
      errors++;
      $display("FAIL count48_flags: lvl=%0d ms=%0d want 0/0", level, ms);
    end
  endtask

  task automatic test_milestone;
    int ms;
    run_to(16'h0099, 400, ms);
    checks++;
    if (ms != 0) begin
      errors++; $display("FAIL pre_ms: pulses=%0d want=0", ms);
    end
    step(3);
    checks++;
    if (score !== 16'h0099 || milestone !== 1'b0) begin
      errors++;
      $display("FAIL ms_before: score=%h ms=%b want 0099/0", score, milestone);
    end
    step(1);
    checks++;
    if (score !== 16'h0100 || milestone !== 1'b1) begin
      errors++;
      $display("FAIL ms_hit: score=%h ms=%b want 0100/1", score, milestone);
    end
    checks++;
    if (level !== 3'd1) begin
      errors++; $display("FAIL ms_level: got=%0d want=1", level);
    end
    step(1);
    checks++;
    if (milestone !== 1'b0) begin
      errors++; $display("FAIL ms_after: got=%b want=0", milestone);
    end
  endtask

  task automatic test_dead_hi;
    int ms;
    run_to(16'h0150, 300, ms);
    state = 2'b01;
    step(1);
    checks++;
    if (hi_score !== 16'h0150 || new_hi !== 1'b1) begin
      errors++;
      $display("FAIL dead_hi: hi=%h nh=%b want 0150/1", hi_score, new_hi);
    end
    step(5);
    checks++;
    if (score !== 16'h0150 || new_hi !== 1'b1 || level !== 3'd1) begin
      errors++;
      $display("FAIL dead_frozen: s=%h nh=%b lvl=%0d want 0150/1/1",
               score, new_hi, level);
    end
    state = 2'b00;
    step(1);
    checks++;
    if (score !== 16'h0000 || new_hi !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL init_clr: s=%h nh=%b lvl=%0d want 0000/0/0",
               score, new_hi, level);
    end
    checks++;
    if (hi_score !== 16'h0150) begin
      errors++; $display("FAIL init_hi: got=%h want=0150", hi_score);
    end
  endtask

  task automatic test_back_to_back;
    int ms;
    state = 2'b10;
    run_to(16'h0030, 200, ms);
    // Divider is now at its last count: Dead lands on a tick cycle
    step(3);
    state = 2'b01;
    step(1);
    checks++;
    if (score !== 16'h0030 || hi_score !== 16'h0150 || new_hi !== 1'b0) begin
      errors++;
      $display("FAIL tick_dead: s=%h hi=%h nh=%b want 0030/0150/0",
               score, hi_score, new_hi);
    end
    state = 2'b10;
    step(1);
    checks++;
    if (score !== 16'h0031) begin
      errors++; $display("FAIL resume: got=%h want=0031", score);
    end
    state = 2'b11;
    step(1);
    checks++;
    if (score !== 16'h0000 || hi_score !== 16'h0150) begin
      errors++;
      $display("FAIL init11: s=%h hi=%h want 0000/0150", score, hi_score);
    end
  endtask

  task automatic test_reset_mid;
    int ms;
    state = 2'b10;
    run_to(16'h0420, 2000, ms);
    state = 2'b00;
    step(1);
    checks++;
    if (hi_score !== 16'h0150 || score !== 16'h0000) begin
      errors++;
      $display("FAIL direct_init: hi=%h s=%h want 0150/0000",
               hi_score, score);
    end
    state = 2'b10;
    run_to(16'h0420, 2000, ms);
    rst = 1'b1;
    step(1);
    checks++;
    if (score !== 16'h0000 || hi_score !== 16'h0000 ||
        level !== 3'd0 || new_hi !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: s=%h hi=%h lvl=%0d nh=%b want all 0",
               score, hi_score, level, new_hi);
    end
    rst   = 1'b0;
    state = 2'b00;
    step(1);
  endtask

  task automatic test_saturate;
    int ms;
    int bad;
    state = 2'b10;
    run_to(16'h9999, 45000, ms);
    checks++;
    if (ms != 99) begin
      errors++; $display("FAIL ms_total: got=%0d want=99", ms);
    end
    checks++;
    if (level !== 3'd7) begin
      errors++; $display("FAIL lvl_sat: got=%0d want=7", level);
    end
    bad = 0;
    ms  = 0;
    repeat (80) begin
      step(1);
      if (score !== 16'h9999) bad++;
      if (milestone !== 1'b0) ms++;
    end
    checks++;
    if (bad != 0 || ms != 0) begin
      errors++;
      $display("FAIL sat_hold: bad_cycles=%0d pulses=%0d want 0/0", bad, ms);
    end
    state = 2'b01;
    step(1);
    checks++;
    if (hi_score !== 16'h9999 || new_hi !== 1'b1) begin
      errors++;
      $display("FAIL sat_hi: hi=%h nh=%b want 9999/1", hi_score, new_hi);
    end
  endtask

  initial begin
    rst   = 1'b1;
    state = 2'b10;
    test_reset();
    test_count();
    test_milestone();
    test_dead_hi();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
